nco_sweep_controller: RTL and testbench
=======================================

Name: nco_sweep_controller

Overview:
- Sequencer for the sinewave/NCO generator in the SDR front end.
- Produces the generator's sample clock-enable from a programmable clock divider.
- Schedules the generator's phase increment through a stepped linear frequency sweep (chirp/hop list): start increment, signed step, number of steps, dwell per step.
- Supports one-shot and continuous (auto-restart) modes, abort, and a done pulse for the control processor.

Parameters:
- PHASE_WIDTH, 64, width of phase_increment / f_start / f_step.
- DIV_WIDTH, 16, width of the sample-enable divider ratio.
- CNT_WIDTH, 16, width of num_steps, dwell and step_index.

Ports:
- clk  in  1  system clock.
- arst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle request to begin a sweep; sampled only in IDLE.
- abort  in  1  stop the sweep immediately; honoured in any state.
- continuous  in  1  1 = restart the sweep after the last step; 0 = one-shot. Latched at start.
- ce_div  in  DIV_WIDTH  divide ratio; sample_clk_ce pulses once per ce_div+1 clk cycles. Sampled live.
- f_start  in  PHASE_WIDTH  first phase increment, unsigned. Latched at start.
- f_step  in  PHASE_WIDTH  signed increment added per step, two's complement. Latched at start.
- num_steps  in  CNT_WIDTH  number of steps after the first frequency; total frequencies = num_steps+1. Latched at start.
- dwell  in  CNT_WIDTH  each frequency lasts dwell+1 sample enables. Latched at start.
- sample_clk_ce  out  1  one-clk enable pulse to the generator.
- phase_increment  out  PHASE_WIDTH  registered increment driven to the generator.
- step_index  out  CNT_WIDTH  index of the current frequency, 0..num_steps.
- busy  out  1  high in RUN.
- done  out  1  single-cycle pulse at one-shot completion.

Behaviour:
- Reset (arst=1): div_cnt=0; sample_clk_ce=0; phase_increment=0; step_index=0; dwell_cnt=0; busy=0; done=0; state=IDLE. All config shadow registers=0. Reset mid-sweep aborts with no done pulse.
- Divider is free-running in every state, independent of the FSM:
  - If div_cnt >= ce_div: div_cnt<=0 and sample_clk_ce<=1 next cycle.
  - Otherwise div_cnt++ and sample_clk_ce<=0.
  - ce_div=0 gives sample_clk_ce constantly high.
  - The >= compare guarantees recovery when ce_div is lowered on the fly.
  - First pulse after reset release occurs ce_div+1 cycles later.
- States: IDLE, RUN.
- IDLE:
  - phase_increment holds its last value (0 after reset or abort).
  - On start=1 and abort=0: latch config, phase_increment<=f_start, step_index<=0, dwell_cnt<=0, busy<=1, enter RUN. This takes effect the cycle after start.
- RUN: the FSM advances only on cycles where the registered sample_clk_ce=1.
  - If dwell_cnt<dwell: dwell_cnt++.
  - Else (dwell_cnt==dwell), dwell_cnt<=0, then:
    - If step_index<num_steps: phase_increment<=phase_increment+f_step (modulo 2^PHASE_WIDTH, wraps silently); step_index++.
    - Else if continuous=1: phase_increment<=f_start; step_index<=0.
    - Else: enter IDLE; busy<=0; done<=1 for exactly one cycle. phase_increment holds the final frequency.
- start while in RUN is ignored. Config inputs changing during RUN have no effect, except ce_div.
- abort=1 in any state takes effect next cycle: IDLE, busy=0, phase_increment=0, step_index=0, dwell_cnt=0, done=0. abort takes priority over start and over a simultaneous completion, so no done pulse.
- num_steps=0: f_start is held for dwell+1 enables, then done (one-shot) or repeats (continuous).
- Latencies:
  - start to phase_increment=f_start: 1 cycle.
  - Last qualifying enable to done: 1 cycle.
  - Frequency change is registered on the cycle after the qualifying enable, so the generator uses the new increment from its next enable onward.

Test Plan:
- Reset/divider: ce_div=3, release arst. Required: sample_clk_ce high 1 of every 4 cycles; all outputs 0 during reset; ce_div=0 gives ce stuck high.
- One-shot up-sweep: ce_div=0, f_start=100, f_step=+10, num_steps=3, dwell=1, start. Required: phase_increment 100,110,120,130, each held 2 cycles; step_index 0..3; done pulses once 1 cycle after the 8th enable; busy low after; phase_increment stays 130.
- Down-sweep with wrap: f_start=5, f_step=-10 (all-ones pattern minus 9), num_steps=1, dwell=0. Required: phase_increment 5 then 2^64-5; done asserted.
- Continuous: f_start=1000, f_step=+1, num_steps=2, dwell=0, continuous=1. Required: sequence 1000,1001,1002,1000,1001… with no done; busy stays high.
- Abort/priority: abort asserted mid-sweep, also once on the same cycle as start and once on the same cycle as final completion. Required: next cycle busy=0, phase_increment=0, done never pulses.
- Live ce_div / ignored start: during RUN change ce_div 9→2 while div_cnt=7, and pulse start again. Required: ce resumes within 1 cycle at period 3; the sweep is not restarted.

Source files
------------

// File: rtl/nco_sweep_controller.sv
// nco_sweep_controller
//   Sequencer for the sinewave/NCO generator. It provides a free-running
//   sample clock-enable divider and steps the generator's phase increment
//   through a linear frequency sweep. The sweep is defined by a start
//   increment, a signed step, a step count and a dwell per step. It runs
//   one-shot or continuous, can be aborted, and emits a done pulse.
//
// Ports
//   clk, arst         system clock, asynchronous active-high reset
//   start             begin a sweep (sampled in IDLE only)
//   abort             stop immediately, any state
//   continuous        auto-restart after last step (latched at start)
//   ce_div            divider ratio, period ce_div+1 (sampled live)
//   f_start, f_step   first increment / signed per-step delta (latched)
//   num_steps, dwell  steps after the first freq / enables-1 per freq (latched)
//   sample_clk_ce     one-clk enable to the generator
//   phase_increment   registered increment to the generator
//   step_index        current frequency index
//   busy, done        RUN indicator / one-shot completion pulse
module nco_sweep_controller #(
  parameter int unsigned PHASE_WIDTH = 64,
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   continuous,
  input  logic [DIV_WIDTH-1:0]   ce_div,
  input  logic [PHASE_WIDTH-1:0] f_start,
  input  logic [PHASE_WIDTH-1:0] f_step,
  input  logic [CNT_WIDTH-1:0]   num_steps,
  input  logic [CNT_WIDTH-1:0]   dwell,
  output logic                   sample_clk_ce,
  output logic [PHASE_WIDTH-1:0] phase_increment,
  output logic [CNT_WIDTH-1:0]   step_index,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  state_t                 r_state;
  logic [DIV_WIDTH-1:0]   r_div_cnt;
  logic                   r_ce;
  logic [PHASE_WIDTH-1:0] r_phase;
  logic [CNT_WIDTH-1:0]   r_step_idx;
  logic [CNT_WIDTH-1:0]   r_dwell_cnt;
  logic                   r_busy;
  logic                   r_done;

  logic [PHASE_WIDTH-1:0] r_f_start;
  logic [PHASE_WIDTH-1:0] r_f_step;
  logic [CNT_WIDTH-1:0]   r_num_steps;
  logic [CNT_WIDTH-1:0]   r_dwell;
  logic                   r_continuous;

  // Free-running divider. The >= compare lets the counter recover at once
  // when ce_div is lowered below the current count.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_div_cnt <= '0;
      r_ce      <= 1'b0;
    end else if (r_div_cnt >= ce_div) begin
      r_div_cnt <= '0;
      r_ce      <= 1'b1;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_ONE;
      r_ce      <= 1'b0;
    end
  end

  // Sweep FSM. It advances only on the registered enable, so a new increment
  // lands the cycle after the enable that consumed the old one.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state      <= IDLE;
      r_phase      <= '0;
      r_step_idx   <= '0;
      r_dwell_cnt  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_f_start    <= '0;
      r_f_step     <= '0;
      r_num_steps  <= '0;
      r_dwell      <= '0;
      r_continuous <= 1'b0;
    end else if (abort) begin
      // Abort outranks start and a coincident completion: no done pulse.
      r_state     <= IDLE;
      r_phase     <= '0;
      r_step_idx  <= '0;
      r_dwell_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_f_start    <= f_start;
            r_f_step     <= f_step;
            r_num_steps  <= num_steps;
            r_dwell      <= dwell;
            r_continuous <= continuous;
            r_phase      <= f_start;
            r_step_idx   <= '0;
            r_dwell_cnt  <= '0;
            r_busy       <= 1'b1;
            r_state      <= RUN;
          end
        end
        RUN: begin
          if (r_ce) begin
            if (r_dwell_cnt < r_dwell) begin
              r_dwell_cnt <= r_dwell_cnt + CNT_ONE;
            end else begin
              r_dwell_cnt <= '0;
              if (r_step_idx < r_num_steps) begin
                r_phase    <= r_phase + r_f_step;
                r_step_idx <= r_step_idx + CNT_ONE;
              end else if (r_continuous) begin
                r_phase    <= r_f_start;
                r_step_idx <= '0;
              end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sample_clk_ce   = r_ce;
  assign phase_increment = r_phase;
  assign step_index      = r_step_idx;
  assign busy            = r_busy;
  assign done            = r_done;

endmodule

// File: tb/tb_nco_sweep_controller.sv
// tb_nco_sweep_controller
//   Directed bench for nco_sweep_controller: reset and divider, one-shot
//   up-sweep, wrapping down-sweep, continuous mode, abort priority, live
//   ce_div change with an ignored start during RUN.
module tb_nco_sweep_controller;

  logic        clk = 1'b0;
  logic        arst;
  logic        start;
  logic        abort;
  logic        continuous;
  logic [15:0] ce_div;
  logic [63:0] f_start;
  logic [63:0] f_step;
  logic [15:0] num_steps;
  logic [15:0] dwell;
  logic        sample_clk_ce;
  logic [63:0] phase_increment;
  logic [15:0] step_index;
  logic        busy;
  logic        done;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  nco_sweep_controller #(
    .PHASE_WIDTH(64),
    .DIV_WIDTH  (16),
    .CNT_WIDTH  (16)
  ) dut (
    .clk            (clk),
    .arst           (arst),
    .start          (start),
    .abort          (abort),
    .continuous     (continuous),
    .ce_div         (ce_div),
    .f_start        (f_start),
    .f_step         (f_step),
    .num_steps      (num_steps),
    .dwell          (dwell),
    .sample_clk_ce  (sample_clk_ce),
    .phase_increment(phase_increment),
    .step_index     (step_index),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge; inputs are
  // changed at the same point and take effect on the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_cfg(input logic [63:0] fs, input logic [63:0] fd,
                           input logic [15:0] ns, input logic [15:0] dw,
                           input logic cont);
    f_start    = fs;
    f_step     = fd;
    num_steps  = ns;
    dwell      = dw;
    continuous = cont;
  endtask

  logic [7:0]  ce_pat;
  logic [63:0] up_exp [8];
  logic [63:0] cont_exp [6];
  int unsigned ce_cnt;
  bit          synced;

  initial begin
    arst = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    ce_div = 16'd3; f_start = '0; f_step = '0; num_steps = '0; dwell = '0;

    // ---------------- reset / divider ----------------
    tick(); tick();
    chk("rst_ce",    {63'd0, sample_clk_ce}, 64'd0);
    chk("rst_phase", phase_increment, 64'd0);
    chk("rst_idx",   {48'd0, step_index}, 64'd0);
    chk("rst_busy",  {63'd0, busy}, 64'd0);
    chk("rst_done",  {63'd0, done}, 64'd0);
    arst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      ce_pat[i] = sample_clk_ce;
    end
    chk("div4_pattern", {56'd0, ce_pat}, {56'd0, 8'b1000_1000});
    ce_div = 16'd0;
    tick();
    ce_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (sample_clk_ce) ce_cnt++;
    end
    chk("div0_stuck_high", 64'(ce_cnt), 64'd4);

    // ---------------- one-shot up-sweep ----------------
    up_exp = '{64'd100, 64'd110, 64'd110, 64'd120, 64'd120, 64'd130, 64'd130, 64'd130};
    sweep_cfg(64'd100, 64'd10, 16'd3, 16'd1, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("up_first",      phase_increment, 64'd100);
    chk("up_first_busy", {63'd0, busy}, 64'd1);
    chk("up_first_idx",  {48'd0, step_index}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("up_phase%0d", i), phase_increment, up_exp[i]);
      chk($sformatf("up_done%0d", i), {63'd0, done}, (i == 7) ? 64'd1 : 64'd0);
      if (i == 5) chk("up_idx3", {48'd0, step_index}, 64'd3);
    end
    chk("up_busy_end", {63'd0, busy}, 64'd0);
    tick();
    chk("up_done_once", {63'd0, done}, 64'd0);
    chk("up_hold", phase_increment, 64'd130);

    // ---------------- down-sweep with wrap ----------------
    sweep_cfg(64'd5, 64'hFFFF_FFFF_FFFF_FFF6, 16'd1, 16'd0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("dn_first", phase_increment, 64'd5);
    tick();
    chk("dn_wrap", phase_increment, 64'hFFFF_FFFF_FFFF_FFFB);
    chk("dn_idx",  {48'd0, step_index}, 64'd1);
    tick();
    chk("dn_done", {63'd0, done}, 64'd1);
    chk("dn_busy", {63'd0, busy}, 64'd0);
    tick();

    // ---------------- continuous ----------------
    cont_exp = '{64'd1001, 64'd1002, 64'd1000, 64'd1001, 64'd1002, 64'd1000};
    sweep_cfg(64'd1000, 64'd1, 16'd2, 16'd0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    continuous = 1'b0;
    chk("ct_first", phase_increment, 64'd1000);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("ct_phase%0d", i), phase_increment, cont_exp[i]);
      chk($sformatf("ct_nodone%0d", i), {63'd0, done}, 64'd0);
      chk($sformatf("ct_busy%0d", i), {63'd0, busy}, 64'd1);
    end

    // ---------------- abort mid-sweep ----------------
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy",  {63'd0, busy}, 64'd0);
    chk("ab_phase", phase_increment, 64'd0);
    chk("ab_idx",   {48'd0, step_index}, 64'd0);
    chk("ab_done",  {63'd0, done}, 64'd0);

    // abort together with start
    sweep_cfg(64'd77, 64'd1, 16'd2, 16'd0, 1'b0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abst_busy",  {63'd0, busy}, 64'd0);
    chk("abst_phase", phase_increment, 64'd0);
    tick();
    chk("abst_idle", {63'd0, busy}, 64'd0);

    // abort together with final completion
    sweep_cfg(64'd7, 64'd1, 16'd0, 16'd0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("abfin_start", phase_increment, 64'd7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abfin_done",  {63'd0, done}, 64'd0);
    chk("abfin_busy",  {63'd0, busy}, 64'd0);
    chk("abfin_phase", phase_increment, 64'd0);
    tick();
    chk("abfin_done2", {63'd0, done}, 64'd0);

    // ---------------- live ce_div / ignored start ----------------
    ce_div = 16'd9;
    synced = 1'b0;
    for (int i = 0; i < 20 && !synced; i++) begin
      tick();
      if (sample_clk_ce) synced = 1'b1;
    end
    chk("ld_sync", {63'd0, synced}, 64'd1);
    // divider counter is now 0
    sweep_cfg(64'd50, 64'd5, 16'd5, 16'd0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ld_first", phase_increment, 64'd50);
    for (int i = 0; i < 16; i++) tick();
    // counter is 7; one enable has been consumed
    chk("ld_pre_phase", phase_increment, 64'd55);
    chk("ld_pre_ce",    {63'd0, sample_clk_ce}, 64'd0);
    ce_div = 16'd2;
    sweep_cfg(64'd999, 64'd1, 16'd1, 16'd0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ld_ce_resume",  {63'd0, sample_clk_ce}, 64'd1);
    chk("ld_no_restart", phase_increment, 64'd55);
    chk("ld_idx_kept",   {48'd0, step_index}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      ce_pat[i] = sample_clk_ce;
    end
    chk("ld_period3",  {61'd0, ce_pat[2:0]}, {61'd0, 3'b100});
    chk("ld_phase",    phase_increment, 64'd60);
    chk("ld_idx",      {48'd0, step_index}, 64'd2);
    chk("ld_busy",     {63'd0, busy}, 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
